adc_scan_sequencer: RTL and testbench

- Multi-channel scan scheduler that sits in front of the 12-bit SAR ADC controller and shares that single converter between up to NCH analog mux inputs.
- Steps through an enabled-channel mask and drives the analog mux select.
- Waits a programmable settle time per channel, then issues 2^OSR_LOG2 back-to-back conversions through the controller's active-low enable/ack handshake.
- Accumulates and averages the samples, then publishes one tagged result per channel. Supports single-scan and continuous modes.

---
 rtl/adc_seq_pkg.sv | 28 ++
 rtl/adc_chan_pick.sv | 30 +++
 rtl/adc_scan_sequencer.sv | 174 +++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_seq_pkg
// Brief    : Shared constants and state encoding for the ADC scan sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package adc_seq_pkg;

   localparam int DEF_WIDTH = 12;
   localparam int ADC_LAT   = DEF_WIDTH + 2;
   localparam int DEF_TMO   = DEF_WIDTH + 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SELECT = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_CONV   = 3'd3;
   localparam logic [2:0] ST_ACC    = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_SELECT = ST_SELECT,
      S_SETTLE = ST_SETTLE,
      S_CONV   = ST_CONV,
      S_ACC    = ST_ACC
   } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_chan_pick.sv
`default_nettype none
// ============================================================================
// Module   : adc_chan_pick
// Brief    : Finds the lowest set mask bit at or above start_idx.
// Revision : 1.0 - initial release
// ============================================================================
module adc_chan_pick #(
   parameter int NCH = 8,
   parameter int CHW = $clog2(NCH)
) (
   input  logic [NCH-1:0] mask,
   input  logic [CHW:0]   start_idx,
   output logic [CHW-1:0] idx,
   output logic           none_left
);

   // Descending scan so the last hit wins, leaving the lowest eligible index.
   always_comb begin
      idx       = '0;
      none_left = 1'b1;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask[i] && (i >= int'(start_idx))) begin
            idx       = CHW'(i);
            none_left = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_sequencer
// Brief    : Scans enabled mux channels, oversamples each through the shared
//            SAR ADC controller and publishes one averaged result per channel.
// Revision : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer
   import adc_seq_pkg::*;
#(
   parameter int WIDTH    = 12,
   parameter int NCH      = 8,
   parameter int CHW      = $clog2(NCH),
   parameter int OSR_LOG2 = 2,
   parameter int SETW     = 8,
   parameter int TMO      = DEF_TMO + (WIDTH - DEF_WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             continuous,
   input  logic [NCH-1:0]   ch_mask,
   input  logic [SETW-1:0]  settle_cycles,
   input  logic             adc_busy,
   input  logic             adc_ack,
   input  logic [WIDTH-1:0] adc_data,
   output logic             adc_en_,
   output logic [CHW-1:0]   mux_sel,
   output logic             result_valid,
   output logic [CHW-1:0]   result_ch,
   output logic [WIDTH-1:0] result_data,
   output logic             scan_done,
   output logic             timeout_err,
   output logic             busy
);

   localparam int ACCW = WIDTH + OSR_LOG2;
   localparam int CNTW = OSR_LOG2 + 1;
   localparam int TMRW = $clog2(TMO + 1);
   localparam logic [CNTW-1:0] C_NSAMP = CNTW'(1 << OSR_LOG2);
   localparam logic [CHW:0]    C_ONE   = (CHW + 1)'(1);

   state_t          r_state;
   logic [NCH-1:0]  r_mask;
   logic [SETW-1:0] r_settle;
   logic [SETW-1:0] r_set_cnt;
   logic [ACCW-1:0] r_acc;
   logic [CNTW-1:0] r_cnt;
   logic [TMRW-1:0] r_tmr;
   logic            r_first;

   logic [CHW:0]    w_start_idx;
   logic [CHW-1:0]  w_pick;
   logic            w_none_left;
   logic            w_timeout;
   logic            w_ch_done;
   logic            w_scan_end;

   assign w_start_idx = r_first ? '0 : ({1'b0, mux_sel} + C_ONE);

   adc_chan_pick #(
      .NCH (NCH),
      .CHW (CHW)
   ) u_pick (
      .mask      (r_mask),
      .start_idx (w_start_idx),
      .idx       (w_pick),
      .none_left (w_none_left)
   );

   // The controller converts while en_ is low and returns to idle on ack.
   assign adc_en_ = (r_state == S_CONV) ? adc_ack : 1'b1;

   assign w_timeout  = (r_state == S_CONV) && !adc_ack && (r_tmr == TMRW'(TMO - 1));
   assign w_ch_done  = (r_state == S_ACC) && (r_cnt == C_NSAMP);
   // Lookahead from the current channel lets scan_done share the last result cycle.
   assign w_scan_end = w_none_left && ((r_state == S_SELECT) || w_ch_done || w_timeout);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_mask       <= '0;
         r_settle     <= '0;
         r_set_cnt    <= '0;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_tmr        <= '0;
         r_first      <= 1'b0;
         mux_sel      <= '0;
         result_valid <= 1'b0;
         result_ch    <= '0;
         result_data  <= '0;
         scan_done    <= 1'b0;
         timeout_err  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         scan_done    <= 1'b0;
         timeout_err  <= 1'b0;
         busy         <= (r_state != S_IDLE);
         r_tmr        <= '0;

         if (stop) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_mask   <= ch_mask;
                     r_settle <= settle_cycles;
                     r_first  <= 1'b1;
                     r_state  <= S_SELECT;
                  end
               end
               S_SELECT: begin
                  if (!w_none_left) begin
                     mux_sel <= w_pick;
                  end
                  r_first   <= 1'b0;
                  r_set_cnt <= r_settle;
                  r_acc     <= '0;
                  r_cnt     <= '0;
                  r_state   <= ((r_settle != '0) || adc_busy) ? S_SETTLE : S_CONV;
               end
               S_SETTLE: begin
                  if (r_set_cnt > SETW'(1)) begin
                     r_set_cnt <= r_set_cnt - SETW'(1);
                  end else if (!adc_busy) begin
                     r_state <= S_CONV;
                  end
               end
               S_CONV: begin
                  if (adc_ack) begin
                     r_acc   <= r_acc + ACCW'(adc_data);
                     r_cnt   <= r_cnt + CNTW'(1);
                     r_state <= S_ACC;
                  end else if (w_timeout) begin
                     timeout_err <= 1'b1;
                     r_state     <= S_SELECT;
                  end else begin
                     r_tmr <= r_tmr + TMRW'(1);
                  end
               end
               S_ACC: begin
                  if (w_ch_done) begin
                     result_valid <= 1'b1;
                     result_ch    <= mux_sel;
                     result_data  <= WIDTH'(r_acc >> OSR_LOG2);
                     r_state      <= S_SELECT;
                  end else if (!adc_busy) begin
                     r_state <= S_CONV;
                  end
               end
               default: r_state <= S_IDLE;
            endcase

            if (w_scan_end) begin
               scan_done <= 1'b1;
               if (continuous) begin
                  r_mask   <= ch_mask;
                  r_settle <= settle_cycles;
                  r_first  <= 1'b1;
                  r_state  <= S_SELECT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_scan_sequencer
// Brief    : Self-checking bench with a behavioural ADC and a per-scan model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

   localparam int WIDTH  = 12;
   localparam int NCH    = 8;
   localparam int CHW    = 3;
   localparam int OSR    = 2;
   localparam int SETW   = 8;
   localparam int NS     = 4;
   localparam int T_CONV = 14;
   localparam int T_TMO  = 20;

   logic             clk = 1'b0;
   logic             reset, start, stop, continuous;
   logic [NCH-1:0]   ch_mask;
   logic [SETW-1:0]  settle_cycles;
   logic             adc_busy, adc_ack;
   logic [WIDTH-1:0] adc_data;
   logic             adc_en_;
   logic [CHW-1:0]   mux_sel;
   logic             result_valid;
   logic [CHW-1:0]   result_ch;
   logic [WIDTH-1:0] result_data;
   logic             scan_done, timeout_err, busy;

   always #5 clk = ~clk;

   adc_scan_sequencer #(
      .WIDTH(WIDTH), .NCH(NCH), .CHW(CHW), .OSR_LOG2(OSR), .SETW(SETW)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
      .ch_mask(ch_mask), .settle_cycles(settle_cycles), .adc_busy(adc_busy),
      .adc_ack(adc_ack), .adc_data(adc_data), .adc_en_(adc_en_), .mux_sel(mux_sel),
      .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
      .scan_done(scan_done), .timeout_err(timeout_err), .busy(busy)
   );

   // ADC model: acks after T_CONV low cycles; sample = base_mul*channel + dvals[k]
   int               base_mul = 0;
   logic [WIDTH-1:0] dvals [NS];
   logic [NCH-1:0]   noack = '0;
   int               lowcnt = 0;
   int               k = 0;

   always @(posedge clk) begin
      if (adc_en_) lowcnt <= 0;
      else         lowcnt <= lowcnt + 1;
      if (!busy)        k <= 0;
      else if (adc_ack) k <= (k + 1) % NS;
   end

   assign adc_ack  = (lowcnt == T_CONV) && !noack[mux_sel];
   assign adc_busy = ~adc_en_;
   assign adc_data = WIDTH'(base_mul * int'(mux_sel) + int'(dvals[k]));

   // Monitor
   int cyc = 0, nsd = 0, ntmo = 0, nwin14 = 0, nwin20 = 0, nwin_other = 0, run = 0;
   int sd_alone = 0, last_sd_cyc = 0, busy_fall_cyc = 0;
   logic prev_en = 1'b1, prev_busy = 1'b0;
   logic [CHW-1:0]   got_ch[$];
   logic [WIDTH-1:0] got_data[$];
   int               falls[$];

   always @(negedge clk) begin
      cyc++;
      if (result_valid) begin
         got_ch.push_back(result_ch);
         got_data.push_back(result_data);
      end
      if (scan_done) begin
         nsd++;
         last_sd_cyc = cyc;
         if (!result_valid && !timeout_err) sd_alone++;
      end
      if (timeout_err) ntmo++;
      if (!adc_en_) run++;
      else if (run != 0) begin
         if (run == T_CONV)     nwin14++;
         else if (run == T_TMO) nwin20++;
         else                   nwin_other++;
         run = 0;
      end
      if (prev_en && !adc_en_) falls.push_back(cyc);
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_en   = adc_en_;
      prev_busy = busy;
   end

   int checks = 0, failures = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      nsd = 0; ntmo = 0; nwin14 = 0; nwin20 = 0; nwin_other = 0; sd_alone = 0;
      got_ch.delete(); got_data.delete(); falls.delete();
   endtask

   task automatic pulse_start(input logic [7:0] m, input logic [7:0] s);
      ch_mask = m; settle_cycles = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int target, n;
      target = nsd + 1;
      n = 0;
      while (nsd < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check({nm, "_done_seen"}, int'(nsd >= target), 1);
   endtask

   task automatic wait_conv(input string nm);
      int n;
      n = 0;
      while (adc_en_ && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, "_conv_seen"}, int'(!adc_en_), 1);
   endtask

   // Reference: enabled, responsive channels in ascending order, mean of NS samples.
   int exp_ch[$], exp_data[$];
   task automatic model_scan(input logic [7:0] m, input logic [7:0] na);
      int sum;
      exp_ch.delete(); exp_data.delete();
      for (int c = 0; c < NCH; c++) begin
         if (m[c] && !na[c]) begin
            sum = 0;
            for (int j = 0; j < NS; j++) sum += (base_mul * c + int'(dvals[j])) % 4096;
            exp_ch.push_back(c);
            exp_data.push_back(sum / NS);
         end
      end
   endtask

   task automatic compare_model(input string nm);
      check({nm, "_nres"}, got_ch.size(), exp_ch.size());
      for (int i = 0; i < exp_ch.size() && i < got_ch.size(); i++) begin
         check($sformatf("%s_ch%0d", nm, i), int'(got_ch[i]), exp_ch[i]);
         check($sformatf("%s_data%0d", nm, i), int'(got_data[i]), exp_data[i]);
      end
   endtask

   typedef struct {
      logic [7:0] mask;
      logic [7:0] settle;
      int         mul;
      int         d0, d1, d2, d3;
      logic [7:0] na;
      int         exp_nres, exp_last_ch, exp_last_data, exp_tmo, exp_w14, exp_w20, exp_sd_alone;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      vecs[0] = '{8'h05, 8'd3,   100, 7, 7, 7, 7,             8'h00, 2, 2, 207,  0, 8,  0, 0};
      vecs[1] = '{8'h08, 8'd1,   0,   100, 101, 102, 104,     8'h00, 1, 3, 101,  0, 4,  0, 0};
      vecs[2] = '{8'h00, 8'd2,   100, 7, 7, 7, 7,             8'h00, 0, 0, 0,    0, 0,  0, 1};
      vecs[3] = '{8'h06, 8'd0,   100, 7, 7, 7, 7,             8'h02, 1, 2, 207,  1, 4,  1, 0};
      vecs[4] = '{8'h80, 8'd255, 0,   4095, 4095, 4095, 4094, 8'h00, 1, 7, 4094, 0, 4,  0, 0};
      vecs[5] = '{8'hFF, 8'd0,   1,   0, 1, 2, 3,             8'h00, 8, 7, 8,    0, 32, 0, 0};

      for (int j = 0; j < NS; j++) dvals[j] = '0;
      reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      ch_mask = '0; settle_cycles = '0;
      tick(3);
      check("rst_adc_en_", int'(adc_en_), 1);
      check("rst_mux_sel", int'(mux_sel), 0);
      check("rst_result_valid", int'(result_valid), 0);
      check("rst_result_ch", int'(result_ch), 0);
      check("rst_result_data", int'(result_data), 0);
      check("rst_scan_done", int'(scan_done), 0);
      check("rst_timeout_err", int'(timeout_err), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b0;
      tick(2);

      // Table-driven single scans
      for (int i = 0; i < 6; i++) begin
         base_mul = vecs[i].mul;
         dvals[0] = WIDTH'(vecs[i].d0); dvals[1] = WIDTH'(vecs[i].d1);
         dvals[2] = WIDTH'(vecs[i].d2); dvals[3] = WIDTH'(vecs[i].d3);
         noack = vecs[i].na;
         model_scan(vecs[i].mask, vecs[i].na);
         clear_stats();
         pulse_start(vecs[i].mask, vecs[i].settle);
         wait_done($sformatf("v%0d", i), 3000);
         tick(4);
         check($sformatf("v%0d_nres", i), got_ch.size(), vecs[i].exp_nres);
         if (vecs[i].exp_nres > 0 && got_ch.size() > 0) begin
            check($sformatf("v%0d_last_ch", i), int'(got_ch[got_ch.size()-1]), vecs[i].exp_last_ch);
            check($sformatf("v%0d_last_data", i), int'(got_data[got_data.size()-1]), vecs[i].exp_last_data);
         end
         check($sformatf("v%0d_timeouts", i), ntmo, vecs[i].exp_tmo);
         check($sformatf("v%0d_win14", i), nwin14, vecs[i].exp_w14);
         check($sformatf("v%0d_win20", i), nwin20, vecs[i].exp_w20);
         check($sformatf("v%0d_win_other", i), nwin_other, 0);
         check($sformatf("v%0d_sd_alone", i), sd_alone, vecs[i].exp_sd_alone);
         check($sformatf("v%0d_nsd", i), nsd, 1);
         check($sformatf("v%0d_busy_lag", i), busy_fall_cyc - last_sd_cyc, 1);
         check($sformatf("v%0d_busy", i), int'(busy), 0);
         if ($countones(vecs[i].mask) == 1 && vecs[i].na == 8'h00) begin
            check($sformatf("v%0d_nfalls", i), falls.size(), NS);
            for (int j = 1; j < falls.size(); j++)
               check($sformatf("v%0d_spacing%0d", i, j), falls[j] - falls[j-1], 16);
         end
         compare_model($sformatf("v%0d_model", i));
      end
      noack = '0;

      // Continuous mode with a mid-scan mask change
      base_mul = 100;
      dvals[0] = 12'd1; dvals[1] = 12'd2; dvals[2] = 12'd3; dvals[3] = 12'd4;
      clear_stats();
      continuous = 1'b1;
      pulse_start(8'h03, 8'd2);
      wait_conv("cont");
      check("cont_first_ch", int'(mux_sel), 0);
      ch_mask = 8'h80;
      wait_done("cont_scan1", 3000);
      check("cont_scan1_nres", got_ch.size(), 2);
      continuous = 1'b0;
      wait_done("cont_scan2", 3000);
      tick(100);
      check("cont_nres", got_ch.size(), 3);
      if (got_ch.size() == 3) begin
         check("cont_ch0", int'(got_ch[0]), 0);
         check("cont_ch1", int'(got_ch[1]), 1);
         check("cont_ch2", int'(got_ch[2]), 7);
         check("cont_d0", int'(got_data[0]), 2);
         check("cont_d1", int'(got_data[1]), 102);
         check("cont_d2", int'(got_data[2]), 702);
      end
      check("cont_nsd", nsd, 2);
      check("cont_busy", int'(busy), 0);

      // start and stop together: stop wins
      clear_stats();
      ch_mask = 8'h01; settle_cycles = '0; start = 1'b1; stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      tick(30);
      check("startstop_busy", int'(busy), 0);
      check("startstop_no_conv", falls.size(), 0);

      // stop 5 cycles into CONV
      clear_stats();
      pulse_start(8'h01, 8'd0);
      wait_conv("stop");
      tick(5);
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      check("stop_en_high", int'(adc_en_), 1);
      tick(2);
      check("stop_busy", int'(busy), 0);
      tick(100);
      check("stop_nres", got_ch.size(), 0);
      check("stop_nsd", nsd, 0);

      // reset 5 cycles into CONV
      clear_stats();
      pulse_start(8'h01, 8'd0);
      wait_conv("rstc");
      tick(5);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rstc_en_high", int'(adc_en_), 1);
      check("rstc_busy", int'(busy), 0);
      tick(100);
      check("rstc_nres", got_ch.size(), 0);
      check("rstc_nsd", nsd, 0);

      // Normal scan afterwards; a start mid-scan must be ignored
      clear_stats();
      model_scan(8'h01, 8'h00);
      pulse_start(8'h01, 8'd1);
      tick(10);
      pulse_start(8'hFF, 8'd0);
      wait_done("after", 3000);
      tick(4);
      compare_model("after_model");
      check("after_nsd", nsd, 1);

      // Randomized scans against the reference model
      for (int r = 0; r < 12; r++) begin
         automatic logic [7:0] m = 8'($urandom_range(0, 255));
         automatic logic [7:0] s = 8'($urandom_range(0, 6));
         base_mul = int'($urandom_range(0, 500));
         for (int j = 0; j < NS; j++) dvals[j] = WIDTH'($urandom_range(0, 4095));
         noack = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         model_scan(m, noack);
         clear_stats();
         pulse_start(m, s);
         wait_done($sformatf("r%0d", r), 4000);
         tick(4);
         compare_model($sformatf("r%0d", r));
         check($sformatf("r%0d_timeouts", r), ntmo, $countones(m & noack));
         check($sformatf("r%0d_busy", r), int'(busy), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
